// File: rtl/vga_uart_pkg.sv
// Shared constants and types for the UART-to-framebuffer path.
//   H_RES/V_RES/FB_DEPTH : default framebuffer geometry (320x240)
//   ADDR_W               : framebuffer write address width
//   CLK_PER_BIT          : UART bit period in clk cycles (50 MHz / 115200 baud)
//   SYNC_BIT             : rx_data bit that marks a frame sync byte
//   PIX_W                : pixel width carried by a non-sync byte
//   state_t              : decoder state
package vga_uart_pkg;

  localparam int H_RES       = 320;
  localparam int V_RES       = 240;
  localparam int FB_DEPTH    = H_RES * V_RES;
  localparam int ADDR_W      = 17;
  localparam int CLK_PER_BIT = 434;
  localparam int SYNC_BIT    = 7;
  localparam int PIX_W       = 7;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    STREAM    = 1'b1
  } state_t;

endpackage

// File: rtl/pix_out_reg.sv
// Single-entry output holding register with a valid/ready handshake.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_load           : capture i_addr/i_data and raise o_valid next cycle
//   i_addr, i_data   : write to capture
//   i_ready          : downstream accepts the held write this cycle
//   o_valid/o_addr/o_data : held write, stable while o_valid && !i_ready
//   o_busy           : entry is occupied and will not drain this cycle
module pix_out_reg
  import vga_uart_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = PIX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_busy
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: the payload is reset too, because all outputs must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      // A load may coincide with the previous write draining; the entry
      // simply refills and valid stays high.
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_busy  = r_valid && !i_ready;

endmodule

// File: rtl/uart_pixel_writer.sv
// Decodes the UART byte stream into linear framebuffer writes.
// Sync bytes (MSB=1) start a frame at address 0; pixel bytes (MSB=0) are
// written to consecutive addresses y*H_RES+x through one holding register.
//   clk, rst_n          : 50 MHz clock, asynchronous active-low reset
//   rx_valid, rx_data   : received byte strobe and value
//   wr_valid, wr_ready  : framebuffer write handshake
//   wr_addr, wr_data    : write address and 7-bit pixel
//   in_frame            : high while streaming a frame
//   frame_done          : pulse when the last pixel of a frame loads
//   overrun             : sticky, a pixel byte was dropped under backpressure
//   timeout             : pulse when an idle frame is abandoned
module uart_pixel_writer #(
  parameter int H_RES        = vga_uart_pkg::H_RES,
  parameter int V_RES        = vga_uart_pkg::V_RES,
  parameter int ADDR_W       = vga_uart_pkg::ADDR_W,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic              in_frame,
  output logic              frame_done,
  output logic              overrun,
  output logic              timeout
);
  import vga_uart_pkg::*;

  // ADDR_W must satisfy 2**ADDR_W >= H_RES*V_RES.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam int                IDLE_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [IDLE_W-1:0]   r_idle;
  logic                r_overrun, r_frame_done, r_timeout;

  logic w_sync, w_pixel, w_busy, w_load, w_last, w_drop, w_timeout;

  assign w_sync    = rx_valid && rx_data[SYNC_BIT];
  assign w_pixel   = rx_valid && !rx_data[SYNC_BIT];
  assign w_load    = w_pixel && (r_state == STREAM) && !w_busy;
  assign w_drop    = w_pixel && (r_state == STREAM) && w_busy;
  assign w_last    = w_load && (r_next_addr == LAST_ADDR);
  // Fires on the clock that would take the idle count to TIMEOUT_CLKS.
  assign w_timeout = (r_state == STREAM) && !rx_valid && (r_idle == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_SYNC;
    else        r_state <= w_state_next;
  end

  // NOTE: the next-state value is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (w_sync)                                        w_state_next = STREAM;
    else if ((r_state == STREAM) && (w_last || w_timeout)) w_state_next = WAIT_SYNC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr  <= '0;
      r_idle       <= '0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      r_timeout    <= w_timeout;

      if (w_sync || w_last || w_timeout) r_next_addr <= '0;
      else if (w_load)                   r_next_addr <= r_next_addr + ADDR_W'(1);

      if (r_state != STREAM || rx_valid || w_timeout) r_idle <= '0;
      else                                            r_idle <= r_idle + IDLE_W'(1);

      if (w_sync)      r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;
    end
  end

  // A sync or timeout never touches the holding register, so a pending write
  // drains with the address it was loaded with.
  pix_out_reg #(
    .AW (ADDR_W),
    .DW (PIX_W)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_addr  (r_next_addr),
    .i_data  (rx_data[PIX_W-1:0]),
    .i_ready (wr_ready),
    .o_valid (wr_valid),
    .o_addr  (wr_addr),
    .o_data  (wr_data),
    .o_busy  (w_busy)
  );

  assign in_frame   = (r_state == STREAM);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_uart_pixel_writer.sv
// Self-checking bench for uart_pixel_writer on a 4x2 frame with a 100-clock
// idle timeout. Table vectors check per-cycle flags; a scoreboard of expected
// (addr, data) writes is popped on every completed handshake.
module tb_uart_pixel_writer;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic          in_frame, frame_done, overrun, timeout;

  uart_pixel_writer #(
    .H_RES        (4),
    .V_RES        (2),
    .ADDR_W       (AW),
    .TIMEOUT_CLKS (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .in_frame   (in_frame),
    .frame_done (frame_done),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [6:0]    data;
  } wr_t;

  typedef struct {
    bit       rv;
    bit [7:0] d;
    bit       rdy;
    bit       wv, inf, ovr, fd;
    bit       push;
    int       addr;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Completed writes are observed mid-cycle, before the edge that commits them.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", {15'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_addr", {15'd0, wr_addr}, {15'd0, e.addr});
        check("sb_data", {25'd0, wr_data}, {25'd0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [7:0] d);
    wr_t w;
    w.addr = AW'(addr);
    w.data = d[6:0];
    sb.push_back(w);
  endtask

  task automatic send(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  function automatic void add(bit rv, bit [7:0] d, bit rdy, bit wv, bit inf,
                              bit ovr, bit fd, bit push, int addr);
    vec_t v;
    v.rv = rv; v.d = d; v.rdy = rdy; v.wv = wv; v.inf = inf;
    v.ovr = ovr; v.fd = fd; v.push = push; v.addr = addr;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit seen;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; wr_ready = 1'b1;
    repeat (3) step();
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", {15'd0, wr_addr}, 0);
    check("rst_wr_data", {25'd0, wr_data}, 0);
    check("rst_in_frame", in_frame, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    step();

    //   rv  data  rdy wv inf ovr fd push addr
    // Pixel before any sync is dropped silently.
    add(1, 8'h55, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    // Basic stream, latency 1, back-to-back load with same-cycle drain.
    add(1, 8'h80, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h12, 1, 1, 1, 0, 0, 1, 0);
    add(1, 8'h34, 1, 1, 1, 0, 0, 1, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0);
    // Full 4x2 frame: frame_done with addr 7, then a ninth pixel is ignored.
    add(1, 8'h80, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(1, 8'(i + 1), 1, 1, (i != 7), 0, (i == 7), 1, i);
    add(1, 8'h09, 1, 0, 0, 0, 0, 0, 0);
    // Mid-frame sync restarts at address 0 with no frame_done.
    add(1, 8'h80, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h10, 1, 1, 1, 0, 0, 1, 0);
    add(1, 8'h20, 1, 1, 1, 0, 0, 1, 1);
    add(1, 8'h80, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h30, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rx_valid = vecs[i].rv;
      rx_data  = vecs[i].d;
      wr_ready = vecs[i].rdy;
      if (vecs[i].push) push_wr(vecs[i].addr, vecs[i].d);
      step();
      rx_valid = 1'b0;
      check($sformatf("v%0d_wr_valid", i), wr_valid, vecs[i].wv);
      check($sformatf("v%0d_in_frame", i), in_frame, vecs[i].inf);
      check($sformatf("v%0d_overrun", i), overrun, vecs[i].ovr);
      check($sformatf("v%0d_frame_done", i), frame_done, vecs[i].fd);
      check($sformatf("v%0d_timeout", i), timeout, 0);
    end

    // Backpressure: second pixel dropped, held write stable, then drains.
    wr_ready = 1'b0;
    send(8'h80);
    push_wr(0, 8'h01);
    send(8'h01);
    send(8'h02);
    check("bp_overrun", overrun, 1);
    repeat (3) step();
    check("bp_hold_valid", wr_valid, 1);
    check("bp_hold_addr", {15'd0, wr_addr}, 0);
    check("bp_hold_data", {25'd0, wr_data}, 32'h01);
    wr_ready = 1'b1;
    step();
    check("bp_drained", wr_valid, 0);
    push_wr(1, 8'h03);
    send(8'h03);
    check("bp_next_valid", wr_valid, 1);
    check("bp_next_addr", {15'd0, wr_addr}, 1);
    check("bp_overrun_sticky", overrun, 1);
    send(8'h80);
    check("bp_sync_clears_overrun", overrun, 0);

    // Idle timeout: pulse after exactly 100 idle clocks.
    push_wr(0, 8'h11);
    send(8'h11);
    cnt = 0; seen = 0;
    while (!seen && cnt < 200) begin
      step();
      cnt++;
      if (timeout) seen = 1;
    end
    check("to_seen", seen, 1);
    check("to_idle_clocks", cnt, 100);
    check("to_in_frame", in_frame, 0);
    step();
    check("to_pulse_width", timeout, 0);
    send(8'h33);
    check("to_pixel_ignored", wr_valid, 0);
    send(8'h80);
    push_wr(0, 8'h22);
    send(8'h22);
    check("to_resync_valid", wr_valid, 1);
    check("to_resync_addr", {15'd0, wr_addr}, 0);
    step();

    // Reset mid-write: the pending write is lost immediately.
    wr_ready = 1'b0;
    send(8'h80);
    send(8'h7F);
    check("rw_pending", wr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_valid_dropped", wr_valid, 0);
    check("rw_in_frame", in_frame, 0);
    step();
    rst_n = 1'b1;
    wr_ready = 1'b1;
    repeat (2) step();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
